motor_drive_pwm: RTL and testbench

Parametrised successor to the direct-drive motor controller. Drives N_MOTORS H-bridge channels with a shared PWM counter, per-channel speed ramping and a dead interval on direction reversal. Accepts motion commands over a valid/ready interface and accepts board push-buttons as a synchronised manual override. Sits between the motion planner (motiondir source) and the H-bridge pins.

---
 rtl/motor_pkg.sv | 28 ++
 rtl/motor_drive_pwm_channel.sv | 134 +++++++++++++
 rtl/motor_drive_pwm.sv | 99 +++++++++
 tb/tb_motor_drive_pwm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the multi-channel H-bridge PWM driver: motion codes, bridge
// directions, channel FSM states and motion-code decoding.
package motor_pkg;

    localparam logic [3:0] CodeRest  = 4'd0;
    localparam logic [3:0] CodeFwd   = 4'd1;
    localparam logic [3:0] CodeBwd   = 4'd2;
    localparam logic [3:0] CodeRight = 4'd3;
    localparam logic [3:0] CodeLeft  = 4'd4;

    typedef enum logic [1:0] {DirStop, DirFwd, DirRev} dir_e;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDead = 2'd2;

    // Turning spins the two sides in opposite directions; unknown codes mean rest.
    function automatic dir_e desired_dir(input logic [3:0] code, input logic right_side);
        case (code)
            CodeFwd:   return DirFwd;
            CodeBwd:   return DirRev;
            CodeRight: return right_side ? DirRev : DirFwd;
            CodeLeft:  return right_side ? DirFwd : DirRev;
            default:   return DirStop;
        endcase
    endfunction

endpackage

// File: rtl/motor_drive_pwm_channel.sv
// One H-bridge channel: run/dead/idle FSM, duty ramp, dead counter and registered PWM compare.
// Build option MOTOR_BRAKE_EN: when defined, an idle channel brakes (both bridge inputs high).
module motor_channel
    import motor_pkg::*;
#(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned DEAD_CYCLES = 16,
    parameter bit          RIGHT_SIDE  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          code,
    input  logic [PWM_BITS-1:0] speed,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                bridge_a,
    output logic                bridge_b,
    output logic                dead,
    output logic                busy
);

    localparam int unsigned CntW = $clog2(DEAD_CYCLES + 1);

`ifdef MOTOR_BRAKE_EN
    localparam bit IdleBrake = 1'b1;
`else
    localparam bit IdleBrake = 1'b0;
`endif

    logic [1:0]          state_q, state_d;
    dir_e                dir_q, dir_d, want;
    logic [PWM_BITS-1:0] duty_q, duty_d, target_q, target_d;
    logic [CntW-1:0]     dead_q, dead_d;
    logic                a_d, b_d;

    always_comb begin
        want     = desired_dir(code, RIGHT_SIDE);
        state_d  = state_q;
        dir_d    = dir_q;
        duty_d   = duty_q;
        target_d = target_q;
        dead_d   = dead_q;
        case (state_q)
            StIdle: begin
                if (want != DirStop) begin
                    state_d  = StRun;
                    dir_d    = want;
                    duty_d   = '0;
                    target_d = speed;
                end
            end
            StRun: begin
                if (want == DirStop) begin
                    target_d = '0;
                    if (duty_q == '0) begin
                        state_d = StIdle;
                        dir_d   = DirStop;
                    end
                end else if (want == dir_q) begin
                    target_d = speed;
                end else begin
                    state_d  = StDead;
                    duty_d   = '0;
                    target_d = '0;
                    dead_d   = '0;
                end
                // Ramp toward the freshly chosen target so a retarget never overshoots.
                if (state_d == StRun && tick) begin
                    if (duty_q < target_d) begin
                        duty_d = duty_q + 1'b1;
                    end else if (duty_q > target_d) begin
                        duty_d = duty_q - 1'b1;
                    end
                end
            end
            StDead: begin
                if (dead_q == CntW'(DEAD_CYCLES - 1)) begin
                    if (want != DirStop) begin
                        state_d  = StRun;
                        dir_d    = want;
                        duty_d   = '0;
                        target_d = speed;
                    end else begin
                        state_d  = StIdle;
                        dir_d    = DirStop;
                    end
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                dir_d   = DirStop;
            end
        endcase
    end

    // Outputs follow the next state so DEAD is silent from its very first cycle.
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (state_d == StRun) begin
            a_d = (dir_d == DirFwd) && (pwm_cnt < duty_d);
            b_d = (dir_d == DirRev) && (pwm_cnt < duty_d);
        end else if (state_d == StIdle) begin
            a_d = IdleBrake;
            b_d = IdleBrake;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            dir_q    <= DirStop;
            duty_q   <= '0;
            target_q <= '0;
            dead_q   <= '0;
            bridge_a <= 1'b0;
            bridge_b <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            dead_q   <= dead_d;
            bridge_a <= a_d;
            bridge_b <= b_d;
        end
    end

    assign dead = (state_q == StDead);
    assign busy = dead || (duty_q != target_q);

endmodule

// File: rtl/motor_drive_pwm.sv
// Multi-channel H-bridge PWM driver: command register, button override, shared prescaler/PWM.
// Build option MOTOR_BRAKE_EN (in the channel) selects brake instead of coast when idle.
module motor_drive_pwm
    import motor_pkg::*;
#(
    parameter int unsigned N_MOTORS    = 2,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned RAMP_DIV    = 256,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_dir,
    input  logic [PWM_BITS-1:0] cmd_speed,
    input  logic                btnU,
    input  logic                btnD,
    input  logic                btnL,
    input  logic                btnR,
    output logic [N_MOTORS-1:0] bridge_a,
    output logic [N_MOTORS-1:0] bridge_b,
    output logic                busy
);

    localparam int unsigned PreW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [3:0]          btn_meta, btn_sync;  // {U, D, L, R}
    logic [3:0]          cmd_dir_q;
    logic [PWM_BITS-1:0] cmd_speed_q;
    logic [PreW-1:0]     presc_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                tick;
    logic [3:0]          eff_code;
    logic [PWM_BITS-1:0] eff_speed;
    logic [N_MOTORS-1:0] ch_dead, ch_busy;

    assign tick = (presc_q == PreW'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta    <= '0;
            btn_sync    <= '0;
            cmd_dir_q   <= CodeRest;
            cmd_speed_q <= '0;
            presc_q     <= '0;
            pwm_q       <= '0;
        end else begin
            btn_meta <= {btnU, btnD, btnL, btnR};
            btn_sync <= btn_meta;
            if (cmd_valid && cmd_ready) begin
                cmd_dir_q   <= cmd_dir;
                cmd_speed_q <= cmd_speed;
            end
            presc_q <= tick ? '0 : presc_q + 1'b1;
            pwm_q   <= pwm_q + 1'b1;
        end
    end

    always_comb begin
        eff_code  = cmd_dir_q;
        eff_speed = cmd_speed_q;
        if (btn_sync[3]) begin
            eff_code = CodeFwd;
        end else if (btn_sync[2]) begin
            eff_code = CodeBwd;
        end else if (btn_sync[1]) begin
            eff_code = CodeLeft;
        end else if (btn_sync[0]) begin
            eff_code = CodeRight;
        end
        if (|btn_sync) begin
            eff_speed = '1;
        end
    end

    for (genvar g = 0; g < N_MOTORS; g++) begin : g_ch
        motor_channel #(
            .PWM_BITS    (PWM_BITS),
            .DEAD_CYCLES (DEAD_CYCLES),
            .RIGHT_SIDE  (g % 2 == 1)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .code     (eff_code),
            .speed    (eff_speed),
            .tick     (tick),
            .pwm_cnt  (pwm_q),
            .bridge_a (bridge_a[g]),
            .bridge_b (bridge_b[g]),
            .dead     (ch_dead[g]),
            .busy     (ch_busy[g])
        );
    end

    assign cmd_ready = ~|ch_dead;
    assign busy      = |ch_busy;

endmodule

// File: tb/tb_motor_drive_pwm.sv
// Self-checking bench for motor_drive_pwm: directed scenarios plus random commands,
// checked against settled per-channel behaviour derived from the motion rules.
module tb_motor_drive_pwm;

    localparam int N  = 2;
    localparam int PB = 8;
    localparam int RD = 4;
    localparam int DC = 16;

`ifdef MOTOR_BRAKE_EN
    localparam bit Brake = 1'b1;
`else
    localparam bit Brake = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_dir = '0;
    logic [PB-1:0] cmd_speed = '0;
    logic [3:0]    btns = '0;  // {U, D, L, R}
    logic [N-1:0]  bridge_a, bridge_b;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int reg_code = 0;
    int reg_speed = 0;
    int m_dir[N];  // 0 stop, 1 fwd, 2 rev: settled direction per channel

    motor_drive_pwm #(
        .N_MOTORS    (N),
        .PWM_BITS    (PB),
        .RAMP_DIV    (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_speed (cmd_speed),
        .btnU      (btns[3]),
        .btnD      (btns[2]),
        .btnL      (btns[1]),
        .btnR      (btns[0]),
        .bridge_a  (bridge_a),
        .bridge_b  (bridge_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int want_dir(input int code, input int ch);
        case (code)
            1: return 1;
            2: return 2;
            3: return (ch % 2 == 0) ? 1 : 2;
            4: return (ch % 2 == 0) ? 2 : 1;
            default: return 0;
        endcase
    endfunction

    function automatic int eff_code();
        if (btns[3]) return 1;
        if (btns[2]) return 2;
        if (btns[1]) return 4;
        if (btns[0]) return 3;
        return reg_code;
    endfunction

    function automatic int eff_speed();
        return (btns != 0) ? 255 : reg_speed;
    endfunction

    task automatic send_cmd(input int code, input int speed);
        @(negedge clk);
        check_eq("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_dir   = 4'(code);
        cmd_speed = PB'(speed);
        @(negedge clk);
        cmd_valid = 1'b0;
        reg_code  = code;
        reg_speed = speed;
    endtask

    // Observe the reversal window, let ramps finish, then measure one full PWM period.
    task automatic settle_and_check(input string tag);
        int code, spd, low, ea, eb;
        int new_dir[N];
        bit rev[N];
        bit dead_out[N];
        int ca[N];
        int cb[N];
        bit both[N];
        bit any_rev;
        code = eff_code();
        spd = eff_speed();
        any_rev = 0;
        low = 0;
        for (int ch = 0; ch < N; ch++) begin
            new_dir[ch] = want_dir(code, ch);
            rev[ch] = (m_dir[ch] != 0) && (new_dir[ch] != 0) && (m_dir[ch] != new_dir[ch]);
            any_rev |= rev[ch];
            dead_out[ch] = 0;
            ca[ch] = 0;
            cb[ch] = 0;
            both[ch] = 0;
        end
        repeat (40) begin
            @(negedge clk);
            if (!cmd_ready) begin
                low++;
                for (int ch = 0; ch < N; ch++)
                    if (rev[ch] && (bridge_a[ch] || bridge_b[ch])) dead_out[ch] = 1;
            end
        end
        check_eq({tag, " dead_len"}, low, any_rev ? DC : 0);
        for (int ch = 0; ch < N; ch++)
            if (rev[ch]) check_eq({tag, " dead_quiet"}, int'(dead_out[ch]), 0);
        repeat (1100) @(negedge clk);
        check_eq({tag, " ready"}, int'(cmd_ready), 1);
        check_eq({tag, " busy"}, int'(busy), 0);
        repeat (256) begin
            @(negedge clk);
            for (int ch = 0; ch < N; ch++) begin
                ca[ch] += int'(bridge_a[ch]);
                cb[ch] += int'(bridge_b[ch]);
                if (bridge_a[ch] && bridge_b[ch]) both[ch] = 1;
            end
        end
        for (int ch = 0; ch < N; ch++) begin
            case (new_dir[ch])
                1: begin ea = spd; eb = 0; end
                2: begin ea = 0; eb = spd; end
                default: begin ea = Brake ? 256 : 0; eb = Brake ? 256 : 0; end
            endcase
            check_eq($sformatf("%s ch%0d a_high", tag, ch), ca[ch], ea);
            check_eq($sformatf("%s ch%0d b_high", tag, ch), cb[ch], eb);
            if (new_dir[ch] != 0)
                check_eq($sformatf("%s ch%0d exclusive", tag, ch), int'(both[ch]), 0);
            m_dir[ch] = new_dir[ch];
        end
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, " a_rst"}, int'(bridge_a), 0);
        check_eq({tag, " b_rst"}, int'(bridge_b), 0);
        check_eq({tag, " ready_rst"}, int'(cmd_ready), 1);
        check_eq({tag, " busy_rst"}, int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        reg_code = 0;
        reg_speed = 0;
        for (int ch = 0; ch < N; ch++) m_dir[ch] = 0;
        repeat (2) @(negedge clk);
        check_eq({tag, " ready_after"}, int'(cmd_ready), 1);
        check_eq({tag, " busy_after"}, int'(busy), 0);
    endtask

    initial begin
        for (int ch = 0; ch < N; ch++) m_dir[ch] = 0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("init a", int'(bridge_a), 0);
        check_eq("init b", int'(bridge_b), 0);
        check_eq("init ready", int'(cmd_ready), 1);
        check_eq("init busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send_cmd(1, 128);
        settle_and_check("fwd128");
        send_cmd(2, 128);
        settle_and_check("rev128");
        send_cmd(1, 128);
        settle_and_check("fwd_again");

        @(negedge clk) btns = 4'b0010;
        settle_and_check("btnL");
        @(negedge clk) btns = 4'b0000;
        settle_and_check("btnL_release");

        send_cmd(9, 77);
        settle_and_check("code9_rest");

        @(negedge clk) btns = 4'b1111;
        settle_and_check("all_buttons");
        @(negedge clk) btns = 4'b0000;
        settle_and_check("all_release");

        send_cmd(1, 200);
        repeat (100) @(negedge clk);
        check_eq("mid_ramp busy", int'(busy), 1);
        reset_check("rst_ramp");

        send_cmd(1, 100);
        settle_and_check("pre_dead");
        send_cmd(2, 100);
        repeat (5) @(negedge clk);
        check_eq("mid_dead ready", int'(cmd_ready), 0);
        check_eq("mid_dead outputs", int'(bridge_a | bridge_b), 0);
        reset_check("rst_dead");

        for (int r = 0; r < 8; r++) begin
            send_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            settle_and_check($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
